pch_carry_unit: RTL and testbench
=================================

Name: pch_carry_unit

Overview:
Program-counter high-byte register for the 65C02 core. It is the receiving end of the carry handshake driven by the PC low-byte block.
- Services a held carry (increment) or borrow (decrement) request from PCL.
- Returns a one-cycle carry_done acknowledge and flags the page crossing.
- Supports parallel loads from the data bus and the ADH bus, and drives its byte onto both.

Parameters:
WIDTH, 8, width of the high byte and of all data ports
RESET_VALUE, 8'h00, value of pch_byte after reset

Ports:
clk  in  1  core clock; all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
carry_from_pcl  in  1  level; PCL holds it high until carry_done is seen
borrow_from_pcl  in  1  level; backward-branch borrow, same handshake
carry_done  out  1  one-cycle acknowledge to PCL
page_cross  out  1  one-cycle pulse, coincident with carry_done, when pch_byte actually changed by ±1
load_db  in  1  load pch_byte from db_in
db_in  in  WIDTH  data bus input
db_out  out  WIDTH  current pch_byte
load_adh  in  1  load pch_byte from address_high_in
address_high_in  in  WIDTH  ADH bus input
address_high_out  out  WIDTH  current pch_byte
busy  out  1  high while state is not IDLE

Behaviour:
- Reset (asynchronous, active-low) forces:
  - pch_byte = RESET_VALUE
  - state = IDLE
  - carry_done = 0, page_cross = 0, busy = 0
- Reset asserted mid-handshake aborts it; no acknowledge is issued afterwards.
- db_out and address_high_out are combinational copies of pch_byte.
- FSM states: IDLE, ACK, WAIT_CLR.
  - IDLE: if carry_from_pcl or borrow_from_pcl is high at an edge, adjust pch_byte at that edge and go to ACK.
  - ACK: carry_done = 1 for exactly this one cycle. page_cross = 1 if an adjustment was applied. Next state is WAIT_CLR.
  - WAIT_CLR: stay while carry_from_pcl or borrow_from_pcl is high. Go to IDLE at the first edge where both are low. No further adjustment occurs here: a held level counts as one request.
- Latency: request sampled at edge N; pch_byte is updated at edge N; carry_done is high in cycle N+1.
- Arithmetic is modulo 2^WIDTH:
  - carry: 8'hFF + 1 = 8'h00
  - borrow: 8'h00 - 1 = 8'hFF
- Carry and borrow both high in IDLE: net zero, pch_byte unchanged, handshake still acknowledged, page_cross = 0.
- Load priority, highest first: load_adh, load_db, adjustment.
  - A load in the same cycle as a request in IDLE overwrites the adjustment. The request is still consumed and acknowledged, with page_cross = 0.
- Loads are accepted in any state, including ACK and WAIT_CLR, and do not change the FSM state.
- busy = (state != IDLE).

Decomposition:
- Shared package pc_pkg holds:
  - typedef pch_state_t enum {IDLE, ACK, WAIT_CLR}
  - localparam PC_BYTE_W = 8
  - localparam PCH_RESET = 8'h00
- No sub-module. The ±1 adder and the FSM stay in this one module.

Test Plan:
- Reset released with pch_byte = 8'h00. Pulse load_db with db_in = 8'h12. Hold carry_from_pcl high for 3 cycles. Required: pch_byte = 8'h13 one edge after the sample; carry_done and page_cross high for exactly 1 cycle; no second increment; busy drops after carry_from_pcl goes low.
- load_adh with 8'hFF, then carry. Required: pch_byte wraps to 8'h00; page_cross = 1.
- load_db with 8'h00, then borrow_from_pcl. Required: pch_byte = 8'hFF; carry_done pulses once.
- carry_from_pcl and borrow_from_pcl together with pch_byte = 8'h40. Required: pch_byte stays 8'h40; carry_done = 1; page_cross = 0.
- carry in IDLE with load_db (8'h80) and load_adh (8'h90) in the same cycle. Required: pch_byte = 8'h90; carry_done pulses; page_cross = 0.
- reset_n asserted low during ACK. Required: outputs go to 0 and pch_byte to 8'h00 immediately, with no clock edge needed; no carry_done after release even if carry_from_pcl stays low.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter byte blocks.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_CLR
  } pch_state_t;

  localparam int PC_BYTE_W = 8;
  localparam logic [PC_BYTE_W-1:0] PCH_RESET = 8'h00;

endpackage

// File: rtl/pch_carry_unit.sv
// PC high byte: services the carry/borrow handshake from PCL and accepts
// parallel loads from the data bus and the ADH bus.
module pch_carry_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_BYTE_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PCH_RESET)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             carry_from_pcl,
  input  logic             borrow_from_pcl,
  output logic             carry_done,
  output logic             page_cross,
  input  logic             load_db,
  input  logic [WIDTH-1:0] db_in,
  output logic [WIDTH-1:0] db_out,
  input  logic             load_adh,
  input  logic [WIDTH-1:0] address_high_in,
  output logic [WIDTH-1:0] address_high_out,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pch_state_t       state_q, state_d;
  logic [WIDTH-1:0] pch_q, pch_d;
  logic             carry_done_q, carry_done_d;
  logic             page_cross_q, page_cross_d;
  logic             busy_q, busy_d;
  logic             req;

  assign req = carry_from_pcl | borrow_from_pcl;

  always_comb begin
    state_d      = state_q;
    pch_d        = pch_q;
    carry_done_d = 1'b0;
    page_cross_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d      = ACK;
          carry_done_d = 1'b1;
          // Simultaneous carry and borrow cancel out but are still acknowledged.
          if (carry_from_pcl ^ borrow_from_pcl) begin
            pch_d        = carry_from_pcl ? pch_q + ONE : pch_q - ONE;
            page_cross_d = 1'b1;
          end
        end
      end
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Loads win over any adjustment and never disturb the handshake state.
    if (load_adh) begin
      pch_d        = address_high_in;
      page_cross_d = 1'b0;
    end else if (load_db) begin
      pch_d        = db_in;
      page_cross_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pch_q        <= RESET_VALUE;
      carry_done_q <= 1'b0;
      page_cross_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pch_q        <= pch_d;
      carry_done_q <= carry_done_d;
      page_cross_q <= page_cross_d;
      busy_q       <= busy_d;
    end
  end

  assign carry_done       = carry_done_q;
  assign page_cross       = page_cross_q;
  assign busy             = busy_q;
  assign db_out           = pch_q;
  assign address_high_out = pch_q;

endmodule

// File: tb/tb_pch_carry_unit.sv
// Directed bench for pch_carry_unit with a queue-based acknowledge scoreboard.
module tb_pch_carry_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       carry_from_pcl, borrow_from_pcl;
  logic       carry_done, page_cross;
  logic       load_db, load_adh;
  logic [7:0] db_in, db_out, address_high_in, address_high_out;
  logic       busy;

  typedef struct packed {
    logic [7:0] pch;
    logic       pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   acks_seen = 0;
  int   acks_expected = 0;

  always #5 clk = ~clk;

  pch_carry_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .carry_from_pcl  (carry_from_pcl),
    .borrow_from_pcl (borrow_from_pcl),
    .carry_done      (carry_done),
    .page_cross      (page_cross),
    .load_db         (load_db),
    .db_in           (db_in),
    .db_out          (db_out),
    .load_adh        (load_adh),
    .address_high_in (address_high_in),
    .address_high_out(address_high_out),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: every cycle carry_done is high must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && carry_done === 1'b1) begin
      acks_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(carry_done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_pch", 32'(db_out), 32'(e.pch));
        check("ack_page_cross", 32'(page_cross), 32'(e.pc));
        $display("ack: pch=%02h page_cross=%0b (want %02h/%0b)", db_out, page_cross, e.pch, e.pc);
      end
    end else if (reset_n === 1'b1 && page_cross === 1'b1) begin
      check("page_cross_without_ack", 32'(page_cross), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(input logic [7:0] pch, input logic pc);
    exp_t e;
    e.pch = pch;
    e.pc  = pc;
    exp_q.push_back(e);
    acks_expected++;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic load(input logic use_adh, input logic [7:0] v);
    if (use_adh) begin load_adh = 1'b1; address_high_in = v; end
    else begin load_db = 1'b1; db_in = v; end
    step();
    load_adh = 1'b0;
    load_db  = 1'b0;
    check("load_value", 32'(db_out), 32'(v));
    $display("load %s %02h -> pch=%02h", use_adh ? "adh" : "db", v, db_out);
  endtask

  initial begin
    reset_n = 1'b0;
    carry_from_pcl = 1'b0; borrow_from_pcl = 1'b0;
    load_db = 1'b0; load_adh = 1'b0;
    db_in = 8'h00; address_high_in = 8'h00;
    #12;
    check("reset_pch", 32'(db_out), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(carry_done), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Held carry counts once.
    load(1'b0, 8'h12);
    carry_from_pcl = 1'b1;
    expect_ack(8'h13, 1'b1);
    step();
    check("carry_pch", 32'(db_out), 32'h13);
    check("carry_adh_out", 32'(address_high_out), 32'h13);
    check("carry_busy", 32'(busy), 32'd1);
    step(); step();
    carry_from_pcl = 1'b0;
    check("held_no_reinc", 32'(db_out), 32'h13);
    check("busy_while_held", 32'(busy), 32'd1);
    step();
    check("busy_drop", 32'(busy), 32'd0);
    $display("held carry: pch=%02h busy=%0b", db_out, busy);

    // Carry wraps FF -> 00.
    load(1'b1, 8'hFF);
    carry_from_pcl = 1'b1;
    expect_ack(8'h00, 1'b1);
    step();
    carry_from_pcl = 1'b0;
    check("wrap_pch", 32'(db_out), 32'h00);
    wait_idle("wrap_idle");

    // Borrow wraps 00 -> FF.
    load(1'b0, 8'h00);
    borrow_from_pcl = 1'b1;
    expect_ack(8'hFF, 1'b1);
    step();
    borrow_from_pcl = 1'b0;
    check("borrow_pch", 32'(db_out), 32'hFF);
    wait_idle("borrow_idle");

    // Carry and borrow together: net zero.
    load(1'b0, 8'h40);
    carry_from_pcl = 1'b1; borrow_from_pcl = 1'b1;
    expect_ack(8'h40, 1'b0);
    step();
    carry_from_pcl = 1'b0; borrow_from_pcl = 1'b0;
    check("both_pch", 32'(db_out), 32'h40);
    wait_idle("both_idle");

    // Loads override the adjustment, ADH over DB.
    carry_from_pcl = 1'b1;
    load_db = 1'b1; db_in = 8'h80;
    load_adh = 1'b1; address_high_in = 8'h90;
    expect_ack(8'h90, 1'b0);
    step();
    load_db = 1'b0; load_adh = 1'b0;
    carry_from_pcl = 1'b0;
    check("load_prio_pch", 32'(db_out), 32'h90);
    wait_idle("load_prio_idle");

    // Load accepted in WAIT_CLR without disturbing the handshake.
    carry_from_pcl = 1'b1;
    expect_ack(8'h91, 1'b1);
    step(); step();
    load_db = 1'b1; db_in = 8'h77;
    step();
    load_db = 1'b0;
    check("wait_load_pch", 32'(db_out), 32'h77);
    check("wait_load_busy", 32'(busy), 32'd1);
    step();
    check("wait_hold_pch", 32'(db_out), 32'h77);
    carry_from_pcl = 1'b0;
    wait_idle("wait_load_idle");

    // Reset during ACK aborts immediately.
    load(1'b0, 8'h21);
    carry_from_pcl = 1'b1;
    step();
    carry_from_pcl = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_pch", 32'(db_out), 32'h00);
    check("async_rst_done", 32'(carry_done), 32'd0);
    check("async_rst_pc", 32'(page_cross), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    $display("reset in ACK: pch=%02h done=%0b busy=%0b", db_out, carry_done, busy);
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("post_rst_busy", 32'(busy), 32'd0);

    check("ack_count", 32'(acks_seen), 32'(acks_expected));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
